// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch unit: bus widths, pc step and reset level.
package if_prefetch_pkg;

    localparam int unsigned INST_ADDR_BUS = 32;
    localparam int unsigned INST_BUS      = 32;
    localparam int unsigned PC_INCR       = 4;
    localparam logic        RST_ENABLE    = 1'b0;

endpackage

// File: rtl/if_fifo.sv
// DEPTH-entry FIFO holding {pc, inst} pairs; flush empties it in one cycle.
module if_fifo
    import if_prefetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Credit-based instruction prefetcher with redirect flush.
// Define IF_PREFETCH_BYPASS_EN to present a response to an empty buffer in the same cycle.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = INST_ADDR_BUS,
    parameter int unsigned       INST_W   = INST_BUS,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [INST_W-1:0] mem_rdata_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    input  logic              inst_ready_i,
    output logic              stall_req_o
);
    localparam int unsigned       CNT_W      = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INCR);

    logic [ADDR_W-1:0]        fetch_pc_reg;
    logic [ADDR_W-1:0]        resp_pc_reg;
    logic [ADDR_W-1:0]        redirect_pc_aligned;
    logic [CNT_W-1:0]         outstanding_reg;
    logic [CNT_W-1:0]         discard_reg;
    logic [CNT_W-1:0]         count;
    logic [CNT_W:0]           in_use;
    logic [ADDR_W+INST_W-1:0] head;
    logic fifo_full, fifo_empty;
    logic grant, rsp, accept, drop, push, pop, bypass;

    assign redirect_pc_aligned = redirect_pc_i & ~ADDR_W'(3);
    assign in_use     = {1'b0, count} + {1'b0, outstanding_reg};
    assign mem_req_o  = (in_use < CREDIT_MAX) && !redirect_i && (rst != RST_ENABLE);
    assign mem_addr_o = fetch_pc_reg;

    assign grant  = mem_req_o && mem_gnt_i;
    // A response with nothing owed is a protocol error and is ignored entirely.
    assign rsp    = mem_rvalid_i && (outstanding_reg != '0);
    assign drop   = rsp && (discard_reg != '0);
    assign accept = rsp && (discard_reg == '0);

`ifdef IF_PREFETCH_BYPASS_EN
    assign bypass       = fifo_empty && accept && !redirect_i;
    assign inst_valid_o = !fifo_empty || bypass;
    assign inst_o = !fifo_empty ? head[INST_W-1:0] : (bypass ? mem_rdata_i : '0);
    assign pc_o   = !fifo_empty ? head[ADDR_W+INST_W-1:INST_W] : (bypass ? resp_pc_reg : '0);
`else
    assign bypass       = 1'b0;
    assign inst_valid_o = !fifo_empty;
    assign inst_o = fifo_empty ? '0 : head[INST_W-1:0];
    assign pc_o   = fifo_empty ? '0 : head[ADDR_W+INST_W-1:INST_W];
`endif

    assign stall_req_o = !inst_valid_o;
    assign push = accept && !redirect_i && !fifo_full && !(bypass && inst_ready_i);
    assign pop  = !fifo_empty && inst_ready_i && !redirect_i;

    if_fifo #(
        .WIDTH(ADDR_W + INST_W),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_i),
        .push     (push),
        .push_data({resp_pc_reg, mem_rdata_i}),
        .pop      (pop),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else if (redirect_i) begin
            // Everything still owed after this cycle's response belongs to the old stream.
            fetch_pc_reg    <= redirect_pc_aligned;
            resp_pc_reg     <= redirect_pc_aligned;
            outstanding_reg <= outstanding_reg - CNT_W'(rsp);
            discard_reg     <= outstanding_reg - CNT_W'(rsp);
        end else begin
            if (grant)  fetch_pc_reg <= fetch_pc_reg + PC_STEP;
            if (accept) resp_pc_reg  <= resp_pc_reg + PC_STEP;
            outstanding_reg <= outstanding_reg + CNT_W'(grant) - CNT_W'(rsp);
            discard_reg     <= discard_reg - CNT_W'(drop);
        end
    end

endmodule
